// File: rtl/bus_pkg.sv
// Shared types and default address map for the bus_host_arb interconnect.
package bus_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWaitDev = 2'd1,
      StWaitErr = 2'd2
   } bus_state_e;

   // Wide enough for any practical device count; the top slices what it needs.
   localparam int unsigned DecIdxW = 8;

   typedef struct packed {
      logic               hit;
      logic [DecIdxW-1:0] idx;
   } dec_res_t;

   localparam int unsigned DefNrDevices = 2;

   // Index 0 is the SRAM window, index 1 the peripheral window.
   localparam logic [DefNrDevices-1:0][31:0] DefDevBase = {32'h1000_0000, 32'h0000_0000};
   localparam logic [DefNrDevices-1:0][31:0] DefDevMask = {32'h0000_0fff, 32'h0000_ffff};

endpackage

// File: rtl/bus_rr_arb.sv
// Host arbiter: round-robin when BUS_HOST_ARB_RR_EN is defined, otherwise fixed
// priority with the lowest host index winning.
module bus_rr_arb #(
   parameter int unsigned NrHosts = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic [NrHosts-1:0] req_i,
   output logic [NrHosts-1:0] gnt_o
);

`ifdef BUS_HOST_ARB_RR_EN
   localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

   logic [IdxW-1:0] last_q, last_d;
   logic            found;
   int unsigned     cand;

   // Search starts one past the last winner and wraps around.
   always_comb begin
      gnt_o  = '0;
      last_d = last_q;
      found  = 1'b0;
      cand   = 0;
      for (int unsigned off = 1; off <= NrHosts; off++) begin
         cand = (32'(last_q) + off) % NrHosts;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            last_d      = IdxW'(cand);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= IdxW'(NrHosts - 1);
      end else if (en_i && found) begin
         last_q <= last_d;
      end
   end
`else
   // Isolate the lowest set request bit.
   assign gnt_o = req_i & (~req_i + NrHosts'(1));

   logic unused_ctrl;
   assign unused_ctrl = ^{clk_i, rst_i, en_i};
`endif

endmodule

// File: rtl/bus_host_arb.sv
// Shared-bus interconnect: NrHosts req/gnt/rvalid hosts to NrDevices base/mask
// decoded devices, one outstanding transaction. Macro: BUS_HOST_ARB_RR_EN.
module bus_host_arb
   import bus_pkg::*;
#(
   parameter int unsigned NrHosts   = 2,
   parameter int unsigned NrDevices = DefNrDevices,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter logic [NrDevices-1:0][AddrWidth-1:0] DevBase = DefDevBase,
   parameter logic [NrDevices-1:0][AddrWidth-1:0] DevMask = DefDevMask
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NrHosts-1:0]                    host_req_i,
   output logic [NrHosts-1:0]                    host_gnt_o,
   input  logic [NrHosts-1:0]                    host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
   input  logic [NrHosts-1:0][AddrWidth-1:0]     host_addr_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
   output logic [NrHosts-1:0]                    host_rvalid_o,
   output logic [NrHosts-1:0]                    host_err_o,
   output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
   output logic [NrDevices-1:0]                  device_req_o,
   output logic                                  device_we_o,
   output logic [DataWidth/8-1:0]                device_be_o,
   output logic [AddrWidth-1:0]                  device_addr_o,
   output logic [DataWidth-1:0]                  device_wdata_o,
   input  logic [NrDevices-1:0]                  device_rvalid_i,
   input  logic [NrDevices-1:0]                  device_err_i,
   input  logic [NrDevices-1:0][DataWidth-1:0]   device_rdata_i
);

   localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

   bus_state_e           state_q, state_d;
   logic [HostIdxW-1:0]  host_q, host_d;
   logic [DevIdxW-1:0]   dev_q, dev_d;
   logic [NrHosts-1:0]   arb_gnt;
   logic [HostIdxW-1:0]  win;
   logic [AddrWidth-1:0] sel_addr;
   logic                 dev_done;
   logic                 err_done;
   logic                 eligible;
   logic                 grant;
   dec_res_t             dec;

   // Outputs stay quiet while reset is held, even if a stale response shows up.
   assign dev_done = !rst_i && (state_q == StWaitDev) && device_rvalid_i[dev_q];
   assign err_done = !rst_i && (state_q == StWaitErr);
   assign eligible = !rst_i && ((state_q == StIdle) || err_done || dev_done);
   assign grant    = eligible && (|host_req_i);

   bus_rr_arb #(
      .NrHosts (NrHosts)
   ) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (grant),
      .req_i (host_req_i),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      win = '0;
      for (int h = 0; h < NrHosts; h++) begin
         if (arb_gnt[h]) begin
            win = HostIdxW'(h);
         end
      end
   end

   assign sel_addr = host_addr_i[win];

   // Descending scan so the lowest matching device index wins.
   always_comb begin
      dec = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((sel_addr & ~DevMask[d]) == DevBase[d]) begin
            dec.hit = 1'b1;
            dec.idx = DecIdxW'(d);
         end
      end
   end

   logic unused_dec_idx;
   assign unused_dec_idx = ^dec.idx;

   always_comb begin
      host_gnt_o     = '0;
      device_req_o   = '0;
      device_we_o    = 1'b0;
      device_be_o    = '0;
      device_addr_o  = '0;
      device_wdata_o = '0;
      if (grant) begin
         host_gnt_o     = arb_gnt;
         device_we_o    = host_we_i[win];
         device_be_o    = host_be_i[win];
         device_addr_o  = sel_addr;
         device_wdata_o = host_wdata_i[win];
         if (dec.hit) begin
            device_req_o[dec.idx[DevIdxW-1:0]] = 1'b1;
         end
      end
   end

   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      if (dev_done) begin
         host_rvalid_o[host_q] = 1'b1;
         host_err_o[host_q]    = device_err_i[dev_q];
         host_rdata_o[host_q]  = device_rdata_i[dev_q];
      end else if (err_done) begin
         host_rvalid_o[host_q] = 1'b1;
         host_err_o[host_q]    = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      host_d  = host_q;
      dev_d   = dev_q;
      if (grant) begin
         host_d  = win;
         dev_d   = dec.idx[DevIdxW-1:0];
         state_d = dec.hit ? StWaitDev : StWaitErr;
      end else if (dev_done || err_done) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         host_q  <= '0;
         dev_q   <= '0;
      end else begin
         state_q <= state_d;
         host_q  <= host_d;
         dev_q   <= dev_d;
      end
   end

endmodule

// File: tb/tb_bus_host_arb.sv
// Directed self-checking bench for bus_host_arb; follows BUS_HOST_ARB_RR_EN for
// the arbitration expectations.
module tb_bus_host_arb;
   import bus_pkg::*;

   localparam int NH = 2;
   localparam int ND = 2;
   localparam int AW = 32;
   localparam int DW = 32;

`ifdef BUS_HOST_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NH-1:0]               host_req, host_gnt, host_we, host_rvalid, host_err;
   logic [NH-1:0][DW/8-1:0]     host_be;
   logic [NH-1:0][AW-1:0]       host_addr;
   logic [NH-1:0][DW-1:0]       host_wdata, host_rdata;
   logic [ND-1:0]               dev_req, dev_rvalid, dev_err;
   logic                        dev_we;
   logic [DW/8-1:0]             dev_be;
   logic [AW-1:0]               dev_addr;
   logic [DW-1:0]               dev_wdata;
   logic [ND-1:0][DW-1:0]       dev_rdata;

   int n_chk = 0;
   int n_err = 0;

   bus_host_arb #(
      .NrHosts   (NH),
      .NrDevices (ND),
      .AddrWidth (AW),
      .DataWidth (DW),
      .DevBase   (DefDevBase),
      .DevMask   (DefDevMask)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .host_req_i      (host_req),
      .host_gnt_o      (host_gnt),
      .host_we_i       (host_we),
      .host_be_i       (host_be),
      .host_addr_i     (host_addr),
      .host_wdata_i    (host_wdata),
      .host_rvalid_o   (host_rvalid),
      .host_err_o      (host_err),
      .host_rdata_o    (host_rdata),
      .device_req_o    (dev_req),
      .device_we_o     (dev_we),
      .device_be_o     (dev_be),
      .device_addr_o   (dev_addr),
      .device_wdata_o  (dev_wdata),
      .device_rvalid_i (dev_rvalid),
      .device_err_i    (dev_err),
      .device_rdata_i  (dev_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      host_req   = '0;
      host_we    = '0;
      host_be    = '0;
      host_addr  = '0;
      host_wdata = '0;
      dev_rvalid = '0;
      dev_err    = '0;
      dev_rdata  = '0;
   endtask

   logic [NH-1:0] exp_g, prev_g;
   logic [DW-1:0] data;

   initial begin
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #4;
      chk("rst_gnt", host_gnt, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_err", host_err, 0);
      chk("rst_dreq", dev_req, 0);
      chk("rst_daddr", dev_addr, 0);
      step();

      // Both hosts hammer 0x10 with a 1-cycle RAM on device 0.
      host_addr[0] = 32'h0000_0010;
      host_addr[1] = 32'h0000_0010;
      host_req     = 2'b11;
      prev_g       = '0;
      for (int k = 0; k < 4; k++) begin
         exp_g         = (RrEn && (k % 2 == 1)) ? 2'b10 : 2'b01;
         data          = 32'h1111_0000 + 32'(k);
         dev_rvalid[0] = (k > 0);
         dev_rdata[0]  = data;
         #4;
         chk($sformatf("alt%0d_gnt", k), host_gnt, exp_g);
         chk($sformatf("alt%0d_dreq", k), dev_req, 2'b01);
         chk($sformatf("alt%0d_rvalid", k), host_rvalid, prev_g);
         if (k > 0) begin
            chk($sformatf("alt%0d_rdata", k), host_rdata,
                (prev_g == 2'b01) ? {32'h0, data} : {data, 32'h0});
         end
         prev_g = exp_g;
         step();
      end
      host_req      = '0;
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'h1111_0004;
      #4;
      chk("alt_tail_gnt", host_gnt, 0);
      chk("alt_tail_rvalid", host_rvalid, prev_g);
      step();
      clear_inputs();

      // Unmapped read from host 1.
      host_req     = 2'b10;
      host_addr[1] = 32'h2000_0000;
      #4;
      chk("unm_gnt", host_gnt, 2'b10);
      chk("unm_dreq", dev_req, 0);
      step();
      host_req = '0;
      #4;
      chk("unm_rvalid", host_rvalid, 2'b10);
      chk("unm_err", host_err, 2'b10);
      chk("unm_rdata", host_rdata, 0);
      step();

      // Slow device 1 answers 4 cycles after the grant; host 1 waits.
      host_req     = 2'b01;
      host_addr[0] = 32'h1000_0004;
      #4;
      chk("slow_gnt", host_gnt, 2'b01);
      chk("slow_dreq", dev_req, 2'b10);
      chk("slow_daddr", dev_addr, 32'h1000_0004);
      step();
      host_req     = 2'b10;
      host_addr[1] = 32'h0000_0010;
      #4;
      chk("slow_t1_gnt", host_gnt, 0);
      chk("slow_t1_rvalid", host_rvalid, 0);
      step();
      dev_rvalid[0] = 1'b1;
      #4;
      chk("stray_rvalid", host_rvalid, 0);
      chk("stray_gnt", host_gnt, 0);
      step();
      dev_rvalid[0] = 1'b0;
      #4;
      chk("slow_t3_gnt", host_gnt, 0);
      step();
      dev_rvalid[1] = 1'b1;
      dev_rdata[1]  = 32'hDEAD_BEEF;
      #4;
      chk("slow_t4_rvalid", host_rvalid, 2'b01);
      chk("slow_t4_rdata", host_rdata, {32'h0, 32'hDEAD_BEEF});
      chk("slow_t4_err", host_err, 0);
      chk("slow_t4_gnt", host_gnt, 2'b10);
      chk("slow_t4_dreq", dev_req, 2'b01);
      step();
      host_req     = '0;
      dev_rvalid   = 2'b01;
      dev_rdata[0] = 32'h5555_AAAA;
      #4;
      chk("slow_t5_rvalid", host_rvalid, 2'b10);
      chk("slow_t5_rdata", host_rdata, {32'h5555_AAAA, 32'h0});
      step();
      clear_inputs();

      // Byte write from host 0; host 1 fields hold different values.
      host_req      = 2'b01;
      host_we       = 2'b01;
      host_be[0]    = 4'b0010;
      host_be[1]    = 4'b1111;
      host_addr[0]  = 32'h0000_0100;
      host_addr[1]  = 32'h1000_0000;
      host_wdata[0] = 32'h1234_5678;
      host_wdata[1] = 32'hFFFF_0000;
      #4;
      chk("wr_dreq", dev_req, 2'b01);
      chk("wr_we", dev_we, 1);
      chk("wr_be", dev_be, 4'b0010);
      chk("wr_addr", dev_addr, 32'h0000_0100);
      chk("wr_wdata", dev_wdata, 32'h1234_5678);
      step();
      host_req      = '0;
      dev_rvalid[0] = 1'b1;
      #4;
      chk("wr_rvalid", host_rvalid, 2'b01);
      chk("wr_err", host_err, 0);
      chk("wr_idle_we", dev_we, 0);
      step();
      clear_inputs();

      // Device error is passed through to host 1.
      host_req = 2'b10;
      #4;
      chk("derr_gnt", host_gnt, 2'b10);
      step();
      host_req      = '0;
      dev_rvalid[0] = 1'b1;
      dev_err[0]    = 1'b1;
      #4;
      chk("derr_rvalid", host_rvalid, 2'b10);
      chk("derr_err", host_err, 2'b10);
      step();
      clear_inputs();

      // Reset while waiting on device 1, then a late response arrives.
      host_req     = 2'b01;
      host_addr[0] = 32'h1000_0000;
      #4;
      chk("rw_gnt", host_gnt, 2'b01);
      step();
      host_req = '0;
      rst      = 1'b1;
      step();
      rst           = 1'b0;
      host_req      = 2'b11;
      host_addr[0]  = 32'h0000_0010;
      host_addr[1]  = 32'h0000_0010;
      dev_rvalid[1] = 1'b1;
      dev_rdata[1]  = 32'hBAD0_BAD0;
      #4;
      chk("rw_late_rvalid", host_rvalid, 0);
      chk("rw_first_gnt", host_gnt, 2'b01);
      step();
      host_req     = 2'b10;
      dev_rvalid   = 2'b01;
      dev_rdata[0] = 32'h7777_0001;
      #4;
      chk("rw_resp0", host_rvalid, 2'b01);
      chk("rw_rdata0", host_rdata, {32'h0, 32'h7777_0001});
      chk("rw_gnt1", host_gnt, 2'b10);
      step();
      host_req     = '0;
      dev_rdata[0] = 32'h7777_0002;
      #4;
      chk("rw_resp1", host_rvalid, 2'b10);
      chk("rw_rdata1", host_rdata, {32'h7777_0002, 32'h0});
      step();
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
